// File: rtl/sound_write_queue.sv
// Host-side write queue for the SN76489: buffers single-cycle host byte writes in a FIFO and
// replays each byte as a full chip-enable / write-enable cycle timed on the sound-chip clk_en.
module sound_write_queue #(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned WE_HOLD = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             wr,
  input  logic [7:0]       wr_data,
  input  logic             clr_ovf,
  input  logic             snd_ready,
  output logic [0:7]       snd_d,
  output logic             snd_ce_n,
  output logic             snd_we_n,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic [FIFO_AW:0] level,
  output logic             overflow
);

  localparam int unsigned          Depth    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]     LvlFull  = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]     LvlOne   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0]   PtrOne   = FIFO_AW'(1);
  localparam logic [7:0]           HoldLast = 8'(WE_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRelease} state_e;

  state_e               state_q;
  logic [7:0]           mem_q [Depth];
  logic [FIFO_AW-1:0]   wptr_q, rptr_q;
  logic [FIFO_AW:0]     level_q;
  logic [7:0]           cnt_q;
  logic                 ovf_q;
  logic                 push, pop, drop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LvlFull);
  assign level    = level_q;
  assign busy     = (state_q != StIdle);
  assign overflow = ovf_q;

  // A pop in the same cycle frees a slot, so a write while full is still accepted then.
  assign pop  = clk_en && (state_q == StIdle) && !empty;
  assign push = wr && (!full || pop);
  assign drop = wr && !push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LvlOne;
        2'b01:   level_q <= level_q - LvlOne;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // Set wins over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      snd_d    <= '0;
      snd_ce_n <= 1'b1;
      snd_we_n <= 1'b1;
      cnt_q    <= '0;
    end else if (clk_en) begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            snd_d    <= mem_q[rptr_q];
            snd_ce_n <= 1'b0;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          snd_we_n <= 1'b0;
          cnt_q    <= '0;
          state_q  <= StStrobe;
        end
        StStrobe: begin
          if (cnt_q == HoldLast && snd_ready) begin
            snd_we_n <= 1'b1;
            state_q  <= StRelease;
          end else if (cnt_q != HoldLast) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StRelease: begin
          snd_ce_n <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_write_queue.sv
// Directed bench for sound_write_queue: reset, single byte timing, burst order, overflow,
// push/pop collision and ready stall.
module tb_sound_write_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       snd_ready = 1'b1;
  logic [0:7] snd_d;
  logic       snd_ce_n, snd_we_n, full, empty, busy, overflow;
  logic [3:0] level;

  int checks = 0;
  int passes = 0;

  int en_div = 1;
  int div_cnt = 0;
  int tick_cnt = 0;
  int we_low_total = 0;
  int ce_low_total = 0;
  int order_err = 0;
  int seen_n = 0;
  logic [7:0] seen_data [64];
  int         seen_tick [64];
  logic       prev_we = 1'b1;
  logic       prev_ce = 1'b1;
  logic [7:0] prev_d = 8'h00;

  sound_write_queue #(.FIFO_AW(3), .WE_HOLD(32)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .wr(wr), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .snd_ready(snd_ready), .snd_d(snd_d), .snd_ce_n(snd_ce_n),
    .snd_we_n(snd_we_n), .full(full), .empty(empty), .busy(busy), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // clk_en generator plus bus monitor; counts low ticks and records each write strobe.
  always @(negedge clk) begin
    div_cnt = (div_cnt + 1) % en_div;
    clk_en  = (div_cnt == 0);
    if (clk_en) begin
      tick_cnt = tick_cnt + 1;
      if (!snd_we_n) we_low_total = we_low_total + 1;
      if (!snd_ce_n) ce_low_total = ce_low_total + 1;
    end
    if (prev_we && !snd_we_n) begin
      seen_data[seen_n % 64] = snd_d;
      seen_tick[seen_n % 64] = tick_cnt;
      seen_n = seen_n + 1;
    end
    if (!snd_we_n && snd_ce_n) order_err = order_err + 1;
    if (!snd_ce_n && !prev_ce && (snd_d != prev_d)) order_err = order_err + 1;
    prev_we = snd_we_n;
    prev_ce = snd_ce_n;
    prev_d  = snd_d;
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clk);
      if (empty && !busy && snd_ce_n) ok = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bit got;
    repeat (3) @(negedge clk);
    checks++;
    if ({empty, full, busy, overflow, snd_ce_n, snd_we_n} !== 6'b100011)
      $display("FAIL reset_flags got %b want 100011",
               {empty, full, busy, overflow, snd_ce_n, snd_we_n});
    else passes++;
    checks++;
    if (level !== 4'd0 || snd_d !== 8'h00)
      $display("FAIL reset_level_data got level=%0d d=%h want 0/00", level, snd_d);
    else passes++;
    reset = 1'b0;
    // Mid-strobe reset with the sound clock at a quarter of clk.
    en_div = 4;
    write_byte(8'h9F);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (!snd_we_n) got = 1'b1;
    end
    checks++;
    if (!got) $display("FAIL reset_reach_strobe got timeout want we_n low");
    else passes++;
    repeat (10) @(negedge clk);
    write_byte(8'h42);
    write_byte(8'h43);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({snd_ce_n, snd_we_n, empty, busy} !== 4'b1110)
      $display("FAIL reset_async_outputs got %b want 1110", {snd_ce_n, snd_we_n, empty, busy});
    else passes++;
    checks++;
    if (level !== 4'd0 || snd_d !== 8'h00)
      $display("FAIL reset_async_queue got level=%0d d=%h want 0/00", level, snd_d);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    en_div = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int we0, ce0, s0;
    bit ok;
    we0 = we_low_total;
    ce0 = ce_low_total;
    s0  = seen_n;
    write_byte(8'h9F);
    wait_idle(200, ok);
    checks++;
    if (!ok) $display("FAIL single_idle got timeout want idle");
    else passes++;
    checks++;
    if (we_low_total - we0 !== 32)
      $display("FAIL single_we_ticks got %0d want 32", we_low_total - we0);
    else passes++;
    checks++;
    if (ce_low_total - ce0 !== 34)
      $display("FAIL single_ce_ticks got %0d want 34", ce_low_total - ce0);
    else passes++;
    checks++;
    if (seen_n - s0 !== 1 || seen_data[s0 % 64] !== 8'h9F)
      $display("FAIL single_seen got n=%0d d=%h want 1/9f", seen_n - s0, seen_data[s0 % 64]);
    else passes++;
    checks++;
    if (snd_d !== 8'h9F || snd_d[0] !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_hold got d=%h d0=%b busy=%b want 9f/1/0", snd_d, snd_d[0], busy);
    else passes++;
  endtask

  task automatic test_burst();
    logic [7:0] exp [4];
    int s0;
    bit ok;
    exp[0] = 8'h80; exp[1] = 8'h0A; exp[2] = 8'h91; exp[3] = 8'hBF;
    s0 = seen_n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr = 1'b1;
      wr_data = exp[i];
    end
    @(negedge clk);
    wr = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok || seen_n - s0 !== 4)
      $display("FAIL burst_count got ok=%0d n=%0d want 1/4", ok, seen_n - s0);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen_data[(s0 + i) % 64] !== exp[i])
        $display("FAIL burst_order[%0d] got %h want %h", i, seen_data[(s0 + i) % 64], exp[i]);
      else passes++;
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (seen_tick[(s0 + i) % 64] - seen_tick[(s0 + i - 1) % 64] !== 35)
        $display("FAIL burst_spacing[%0d] got %0d want 35", i,
                 seen_tick[(s0 + i) % 64] - seen_tick[(s0 + i - 1) % 64]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    bit got;
    snd_ready = 1'b0;
    write_byte(8'h11);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (busy && empty && !snd_we_n) got = 1'b1;
    end
    checks++;
    if (!got) $display("FAIL ovf_stall got timeout want stalled strobe");
    else passes++;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr = 1'b1;
      wr_data = 8'h21 + 8'(i);
    end
    @(negedge clk);
    wr = 1'b0;
    checks++;
    if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b1)
      $display("FAIL ovf_full got level=%0d full=%b ovf=%b want 8/1/1", level, full, overflow);
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow);
    else passes++;
    wr = 1'b1;
    wr_data = 8'hEE;
    clr_ovf = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 4'd8)
      $display("FAIL ovf_set_wins got ovf=%b level=%0d want 1/8", overflow, level);
    else passes++;
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow);
    else passes++;
  endtask

  task automatic test_collision();
    logic [7:0] exp [9];
    int s0;
    bit got, ok;
    for (int i = 0; i < 7; i++) exp[i] = 8'h21 + 8'(i);
    exp[7] = 8'h28;
    exp[8] = 8'h77;
    s0 = seen_n;
    snd_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    checks++;
    if (!got || full !== 1'b1)
      $display("FAIL coll_pre got idle=%0d full=%b want 1/1", got, full);
    else passes++;
    wr = 1'b1;
    wr_data = 8'h77;
    @(negedge clk);
    wr = 1'b0;
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0 || full !== 1'b1 || busy !== 1'b1)
      $display("FAIL coll_accept got level=%0d ovf=%b full=%b busy=%b want 8/0/1/1",
               level, overflow, full, busy);
    else passes++;
    wait_idle(400, ok);
    checks++;
    if (!ok || seen_n - s0 !== 9)
      $display("FAIL coll_drain got ok=%0d n=%0d want 1/9", ok, seen_n - s0);
    else passes++;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (seen_data[(s0 + i) % 64] !== exp[i])
        $display("FAIL coll_order[%0d] got %h want %h", i, seen_data[(s0 + i) % 64], exp[i]);
      else passes++;
    end
  endtask

  task automatic test_ready_stall();
    int w0, e0, s0;
    logic [7:0] d0;
    bit got, ok;
    s0 = seen_n;
    write_byte(8'h55);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!snd_we_n) got = 1'b1;
    end
    repeat (10) @(negedge clk);
    snd_ready = 1'b0;
    w0 = we_low_total;
    e0 = order_err;
    d0 = snd_d;
    repeat (100) @(negedge clk);
    checks++;
    if (!got || snd_we_n !== 1'b0 || snd_d !== d0 || d0 !== 8'h55)
      $display("FAIL stall_hold got we_n=%b d=%h want 0/55", snd_we_n, snd_d);
    else passes++;
    snd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (snd_we_n !== 1'b1 || snd_ce_n !== 1'b0)
      $display("FAIL stall_release got we_n=%b ce_n=%b want 1/0", snd_we_n, snd_ce_n);
    else passes++;
    checks++;
    if (we_low_total - w0 < 100)
      $display("FAIL stall_len got %0d want >=100", we_low_total - w0);
    else passes++;
    wait_idle(100, ok);
    checks++;
    if (!ok || order_err !== e0 || seen_n - s0 !== 1)
      $display("FAIL stall_end got ok=%0d err=%0d n=%0d want 1/%0d/1", ok, order_err,
               seen_n - s0, e0);
    else passes++;
    checks++;
    if (order_err !== 0) $display("FAIL bus_ordering got %0d want 0", order_err);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_collision();
    test_ready_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
